// File: rtl/crc_pkg.sv
// Shared definitions for the CRC stream checker: Ethernet CRC-32 constants,
// the checker FSM state type and a single-byte CRC update helper.
//   CRC_W                 : CRC register width
//   CRC_POLY              : reflected CRC-32 polynomial (LSB-first shifting)
//   CRC_REG_INITIAL_VALUE : register seed at start of frame
//   CRC_RESIDUE           : register value after a frame plus a correct FCS
package crc_pkg;

    localparam int CRC_W = 32;
    localparam logic [CRC_W-1:0] CRC_POLY              = 32'hEDB8_8320;
    localparam logic [CRC_W-1:0] CRC_REG_INITIAL_VALUE = 32'hFFFF_FFFF;
    localparam logic [CRC_W-1:0] CRC_RESIDUE           = 32'hDEBB_20E3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DROP   = 2'd2
    } crc_stream_state_t;

    // One byte through the reflected CRC, bit 0 of the byte first.
    function automatic logic [CRC_W-1:0] crc_next_byte(input logic [CRC_W-1:0] crc,
                                                       input logic [7:0]       data);
        logic [CRC_W-1:0] c;
        c = crc ^ {{(CRC_W-8){1'b0}}, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_stream_checker_if.sv
// Stream-in / result-out bundle of the CRC stream checker.
//   s_valid/s_data/s_keep/s_last/s_abort : frame beats, no backpressure
//   clr_stats                            : clear-counters pulse
//   res_*                                : per-frame result, strobed by res_valid
//   good_cnt/bad_cnt                     : saturating frame statistics
// master = frame source / result consumer, slave = the checker.
interface crc_stream_checker_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic                s_valid;
    logic [DATA_W-1:0]   s_data;
    logic [DATA_W/8-1:0] s_keep;
    logic                s_last;
    logic                s_abort;
    logic                clr_stats;
    logic                res_valid;
    logic                res_crc_err;
    logic                res_len_err;
    logic                res_abort;
    logic [15:0]         res_byte_cnt;
    logic [CNT_W-1:0]    good_cnt;
    logic [CNT_W-1:0]    bad_cnt;

    modport master (
        output s_valid, s_data, s_keep, s_last, s_abort, clr_stats,
        input  res_valid, res_crc_err, res_len_err, res_abort, res_byte_cnt,
               good_cnt, bad_cnt
    );

    modport slave (
        input  s_valid, s_data, s_keep, s_last, s_abort, clr_stats,
        output res_valid, res_crc_err, res_len_err, res_abort, res_byte_cnt,
               good_cnt, bad_cnt
    );
endinterface

// File: rtl/calculate_new_crc.sv
// Combinational CRC advance over NUM_BYTES bytes, byte 0 in the LSBs.
//   i_crc  : current CRC register
//   i_data : bytes to fold in
//   o_crc  : CRC after all NUM_BYTES bytes
module calculate_new_crc
    import crc_pkg::*;
#(
    parameter int NUM_BYTES = 1
) (
    input  logic [CRC_W-1:0]       i_crc,
    input  logic [8*NUM_BYTES-1:0] i_data,
    output logic [CRC_W-1:0]       o_crc
);

    always_comb begin : p_fold
        logic [CRC_W-1:0] v_crc;
        v_crc = i_crc;
        for (int i = 0; i < NUM_BYTES; i++) begin
            v_crc = crc_next_byte(v_crc, i_data[8*i +: 8]);
        end
        o_crc = v_crc;
    end

endmodule

// File: rtl/crc_stream_checker.sv
// Ethernet frame FCS / length checker with good/bad frame statistics.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : crc_stream_checker_if slave (stream in, results and counters out)
//
// state  | meaning
// IDLE   | between frames; next valid beat is a start of frame
// ACTIVE | inside a frame, CRC and byte count accumulating
// DROP   | frame aborted by PHY error; discard beats until s_last
module crc_stream_checker
    import crc_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int CNT_W         = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    crc_stream_checker_if.slave  bus
);

    localparam int NB = DATA_W / 8;
    localparam int KW = $clog2(NB + 1);
    localparam logic [15:0] MIN_L = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] MAX_L = 16'(MAX_FRAME_LEN);

    crc_stream_state_t r_state, w_state_next;

    logic [CRC_W-1:0] r_crc;
    logic [15:0]      r_cnt;
    logic             r_res_valid, r_res_crc_err, r_res_len_err, r_res_abort;
    logic [15:0]      r_res_byte_cnt;
    logic [CNT_W-1:0] r_good_cnt, r_bad_cnt;

    logic [KW-1:0]    w_keep_cnt, w_nbytes;
    logic [CRC_W-1:0] w_crc_base, w_crc_next;
    logic [CRC_W-1:0] w_crc_opts [0:NB];
    logic [15:0]      w_cnt_base, w_cnt_next;
    logic [16:0]      w_cnt_sum;
    logic             w_len_bad;
    logic             w_result, w_advance;
    logic             w_res_crc_err, w_res_len_err, w_res_abort;
    logic [15:0]      w_res_cnt;
    logic             w_frame_good, w_frame_bad;

    always_comb begin
        w_keep_cnt = '0;
        for (int i = 0; i < NB; i++) begin
            w_keep_cnt = w_keep_cnt + KW'(bus.s_keep[i]);
        end
    end

    assign w_nbytes = bus.s_last ? w_keep_cnt : KW'(NB);

    // A start-of-frame beat is folded onto the seed directly, so the
    // register never has to be re-seeded between back-to-back frames.
    assign w_crc_base = (r_state == IDLE) ? CRC_REG_INITIAL_VALUE : r_crc;
    assign w_cnt_base = (r_state == IDLE) ? 16'd0 : r_cnt;

    assign w_crc_opts[0] = w_crc_base;
    for (genvar k = 1; k <= NB; k++) begin : g_crc
        calculate_new_crc #(.NUM_BYTES(k)) u_crc (
            .i_crc  (w_crc_base),
            .i_data (bus.s_data[8*k-1:0]),
            .o_crc  (w_crc_opts[k])
        );
    end

    always_comb begin
        w_crc_next = w_crc_opts[0];
        for (int k = 1; k <= NB; k++) begin
            if (w_nbytes == KW'(k)) w_crc_next = w_crc_opts[k];
        end
    end

    assign w_cnt_sum  = {1'b0, w_cnt_base} + 17'(w_nbytes);
    assign w_cnt_next = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    // A pinned count means the real length is unknown, hence always a length error.
    assign w_len_bad  = (w_cnt_next < MIN_L) || (w_cnt_next > MAX_L) ||
                        (w_cnt_next == 16'hFFFF);

    always_comb begin
        w_state_next  = r_state;
        w_result      = 1'b0;
        w_advance     = 1'b0;
        w_res_crc_err = 1'b0;
        w_res_len_err = 1'b0;
        w_res_abort   = 1'b0;
        w_res_cnt     = w_cnt_next;
        case (r_state)
            IDLE, ACTIVE: begin
                if (bus.s_valid) begin
                    if (bus.s_abort) begin
                        if (bus.s_last) begin
                            w_result     = 1'b1;
                            w_res_abort  = 1'b1;
                            w_res_cnt    = w_cnt_base;
                            w_state_next = IDLE;
                        end else begin
                            w_state_next = DROP;
                        end
                    end else if (bus.s_last) begin
                        w_result      = 1'b1;
                        w_res_crc_err = (w_crc_next != CRC_RESIDUE);
                        w_res_len_err = w_len_bad;
                        w_state_next  = IDLE;
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = ACTIVE;
                    end
                end
            end
            DROP: begin
                if (bus.s_valid && bus.s_last) begin
                    w_result     = 1'b1;
                    w_res_abort  = 1'b1;
                    w_res_cnt    = r_cnt;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_crc          <= CRC_REG_INITIAL_VALUE;
            r_cnt          <= '0;
            r_res_valid    <= 1'b0;
            r_res_crc_err  <= 1'b0;
            r_res_len_err  <= 1'b0;
            r_res_abort    <= 1'b0;
            r_res_byte_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_res_valid <= w_result;
            if (w_result) begin
                r_res_crc_err  <= w_res_crc_err;
                r_res_len_err  <= w_res_len_err;
                r_res_abort    <= w_res_abort;
                r_res_byte_cnt <= w_res_cnt;
                r_crc          <= CRC_REG_INITIAL_VALUE;
                r_cnt          <= '0;
            end else if (w_advance) begin
                r_crc <= w_crc_next;
                r_cnt <= w_cnt_next;
            end
        end
    end

    assign w_frame_good = r_res_valid && !r_res_crc_err && !r_res_len_err && !r_res_abort;
    assign w_frame_bad  = r_res_valid && !w_frame_good;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else begin
            if (bus.clr_stats)
                r_good_cnt <= w_frame_good ? CNT_W'(1) : '0;
            else if (w_frame_good && (r_good_cnt != '1))
                r_good_cnt <= r_good_cnt + CNT_W'(1);

            if (bus.clr_stats)
                r_bad_cnt <= w_frame_bad ? CNT_W'(1) : '0;
            else if (w_frame_bad && (r_bad_cnt != '1))
                r_bad_cnt <= r_bad_cnt + CNT_W'(1);
        end
    end

    assign bus.res_valid    = r_res_valid;
    assign bus.res_crc_err  = r_res_crc_err;
    assign bus.res_len_err  = r_res_len_err;
    assign bus.res_abort    = r_res_abort;
    assign bus.res_byte_cnt = r_res_byte_cnt;
    assign bus.good_cnt     = r_good_cnt;
    assign bus.bad_cnt      = r_bad_cnt;

endmodule

// File: tb/tb_crc_stream_checker.sv
module tb_crc_stream_checker;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    crc_stream_checker_if #(.DATA_W(32), .CNT_W(32)) bus ();

    crc_stream_checker #(
        .DATA_W(32), .MIN_FRAME_LEN(64), .MAX_FRAME_LEN(1518), .CNT_W(32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int len;
        int flip;
        int abort_beat;
        int gap_beat;
        bit zero_tail;
        bit exp_crc;
        bit exp_len;
        bit exp_abort;
        int exp_cnt;   // negative: length fields not checked (aborted frame)
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    int  errors = 0;
    int  checks = 0;
    int  exp_good = 0;
    int  exp_bad  = 0;
    bit  rv_early;

    logic [3:0] keep_p1;
    assign keep_p1 = bus.s_keep + 4'd1;

    always @(posedge clk) begin
        if (rst_n && bus.s_valid && bus.s_last)
            assert ((bus.s_keep & keep_p1) == 4'd0)
                else $error("non-contiguous s_keep %b on last beat", bus.s_keep);
    end

    // Bit-serial reference CRC-32 (reflected), independent formulation.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_abort = 1'b0;
        bus.s_keep  = '0;
        bus.s_data  = '0;
    endtask

    // Drives one frame; returns with the last beat still on the bus.
    // Payload is a fixed pattern, followed by its FCS transmitted LSB first.
    task automatic send_frame(input int len, input int flip, input int abort_beat,
                              input int gap_beat, input bit zero_tail, input bit no_wait);
        logic [31:0] crc;
        logic [31:0] fcs;
        logic [7:0]  v;
        int nb, total, idx;
        crc = 32'hFFFFFFFF;
        fcs = '0;
        nb = (len + 3) / 4;
        total = nb + (zero_tail ? 1 : 0);
        idx = 0;
        rv_early = 1'b0;
        for (int b = 0; b < total; b++) begin
            if (!(no_wait && b == 0)) begin
                @(negedge clk);
                if (bus.res_valid) rv_early = 1'b1;
            end
            if (b == gap_beat) begin
                drive_idle();
                @(negedge clk);
                if (bus.res_valid) rv_early = 1'b1;
            end
            bus.s_data = '0;
            bus.s_keep = '0;
            for (int j = 0; j < 4; j++) begin
                if (idx < len && b < nb) begin
                    if (idx < len - 4) begin
                        v = 8'((idx * 13 + len) % 256);
                        crc = crc_byte(crc, v);
                        if (idx == len - 5) fcs = ~crc;
                    end else begin
                        v = fcs[8*(idx-(len-4)) +: 8];
                    end
                    if (idx == flip) v = v ^ 8'h01;
                    bus.s_data[8*j +: 8] = v;
                    bus.s_keep[j] = 1'b1;
                    idx++;
                end
            end
            bus.s_valid = 1'b1;
            bus.s_last  = (b == total - 1);
            bus.s_abort = (b == abort_beat);
        end
    endtask

    // Called at the negedge one cycle after the last beat.
    task automatic check_now(input string tag, input vec_t v);
        chk({tag, "_res_valid"}, 64'(bus.res_valid), 64'd1);
        chk({tag, "_abort"},     64'(bus.res_abort), 64'(v.exp_abort));
        chk({tag, "_crc_err"},   64'(bus.res_crc_err), 64'(v.exp_crc));
        if (v.exp_cnt >= 0) begin
            chk({tag, "_len_err"},  64'(bus.res_len_err), 64'(v.exp_len));
            chk({tag, "_byte_cnt"}, 64'(bus.res_byte_cnt), 64'(v.exp_cnt));
        end
        chk({tag, "_good_pre"}, 64'(bus.good_cnt), 64'(exp_good));
        chk({tag, "_bad_pre"},  64'(bus.bad_cnt),  64'(exp_bad));
        if (!v.exp_crc && !v.exp_len && !v.exp_abort) exp_good++;
        else exp_bad++;
    endtask

    initial begin
        //            len   flip abrt gap zt crc len abt cnt
        vecs[0]  = '{64,    -1,  -1,  -1, 0, 0,  0,  0,  64};
        vecs[1]  = '{64,    10,  -1,  -1, 0, 1,  0,  0,  64};
        vecs[2]  = '{65,    -1,  -1,  -1, 0, 0,  0,  0,  65};
        vecs[3]  = '{60,    -1,  -1,  -1, 0, 0,  1,  0,  60};
        vecs[4]  = '{64,    -1,   3,  -1, 0, 0,  0,  1,  -1};
        vecs[5]  = '{64,    -1,  -1,   5, 0, 0,  0,  0,  64};
        vecs[6]  = '{1518,  -1,  -1,  -1, 0, 0,  0,  0,  1518};
        vecs[7]  = '{1519,  -1,  -1,  -1, 0, 0,  1,  0,  1519};
        vecs[8]  = '{63,    -1,  -1,  -1, 0, 0,  1,  0,  63};
        vecs[9]  = '{64,    -1,  -1,  -1, 1, 0,  0,  0,  64};
        vecs[10] = '{66,    -1,  -1,   2, 0, 0,  0,  0,  66};
        vecs[11] = '{64,    -1,  15,  -1, 0, 0,  0,  1,  -1};
        vecs[12] = '{70000, -1,  -1,  -1, 0, 0,  1,  0,  65535};

        rst_n = 1'b0;
        drive_idle();
        bus.clr_stats = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_byte_cnt",  64'(bus.res_byte_cnt), 64'd0);
        chk("rst_crc_err",   64'(bus.res_crc_err), 64'd0);
        chk("rst_good",      64'(bus.good_cnt), 64'd0);
        chk("rst_bad",       64'(bus.bad_cnt), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            send_frame(vecs[i].len, vecs[i].flip, vecs[i].abort_beat,
                       vecs[i].gap_beat, vecs[i].zero_tail, 1'b0);
            chk($sformatf("v%0d_no_early_rv", i), 64'(rv_early), 64'd0);
            @(negedge clk);
            check_now($sformatf("v%0d", i), vecs[i]);
            drive_idle();
            @(negedge clk);
            chk($sformatf("v%0d_rv_one_cycle", i), 64'(bus.res_valid), 64'd0);
            chk($sformatf("v%0d_crc_err_hold", i), 64'(bus.res_crc_err), 64'(vecs[i].exp_crc));
            chk($sformatf("v%0d_good", i), 64'(bus.good_cnt), 64'(exp_good));
            chk($sformatf("v%0d_bad", i),  64'(bus.bad_cnt),  64'(exp_bad));
        end

        // Back-to-back good frames, clr_stats coincident with the second result.
        send_frame(64, -1, -1, -1, 1'b0, 1'b0);
        @(negedge clk);
        check_now("b2b_a", vecs[0]);
        send_frame(64, -1, -1, -1, 1'b0, 1'b1);
        chk("b2b_b_no_early_rv", 64'(rv_early), 64'd0);
        @(negedge clk);
        check_now("b2b_b", vecs[0]);
        drive_idle();
        bus.clr_stats = 1'b1;
        @(negedge clk);
        bus.clr_stats = 1'b0;
        exp_good = 1;
        exp_bad  = 0;
        chk("b2b_clr_good", 64'(bus.good_cnt), 64'd1);
        chk("b2b_clr_bad",  64'(bus.bad_cnt),  64'd0);

        // Reset pulsed mid-frame.
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = $urandom;
            bus.s_keep  = 4'hF;
            bus.s_last  = 1'b0;
            bus.s_abort = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        chk("midrst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("midrst_byte_cnt",  64'(bus.res_byte_cnt), 64'd0);
        chk("midrst_good",      64'(bus.good_cnt), 64'd0);
        chk("midrst_bad",       64'(bus.bad_cnt), 64'd0);
        rst_n = 1'b1;
        exp_good = 0;
        exp_bad  = 0;
        rv_early = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.res_valid) rv_early = 1'b1;
        end
        chk("midrst_no_rv", 64'(rv_early), 64'd0);
        chk("midrst_good_after", 64'(bus.good_cnt), 64'd0);
        chk("midrst_bad_after",  64'(bus.bad_cnt), 64'd0);

        // First beat after reset release starts a fresh frame.
        send_frame(64, -1, -1, -1, 1'b0, 1'b0);
        @(negedge clk);
        check_now("post_rst", vecs[0]);
        drive_idle();
        @(negedge clk);
        chk("post_rst_good", 64'(bus.good_cnt), 64'(exp_good));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
